// File: rtl/seg7_pkg.sv
// Shared types, constants and helpers for the multiplexed 7-segment scan controller.
package seg7_pkg;

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   // Segment pattern a..g with every segment dark, in active-high sense.
   localparam logic [6:0] SEG_OFF = 7'b000_0000;

   function automatic logic [6:0] seg_pol(input logic [6:0] seg, input logic active_low);
      logic [6:0] res;
      if (active_low) begin
         res = ~seg;
      end else begin
         res = seg;
      end
      return res;
   endfunction

   // Phase counter width; never below one bit so degenerate parameters still elaborate.
   function automatic int unsigned cnt_width(input int unsigned refresh_div, input int unsigned guard);
      int unsigned m;
      int unsigned w;
      if (refresh_div > guard) begin
         m = refresh_div;
      end else begin
         m = guard;
      end
      w = $clog2(m);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero blank mask: digit k>0 is blank when it and every more significant digit are zero.
module seg7_lz_mask
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 2,
   parameter int LZ_BLANK   = 1
) (
   input  logic [4*NUM_DIGITS-1:0] active,
   output logic [NUM_DIGITS-1:0]   blank
);

   // Walk from the most significant digit down; digit 0 always stays visible.
   always_comb begin
      logic upper_zero;
      blank      = '0;
      upper_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         upper_zero = upper_zero & (active[4*k +: 4] == 4'd0);
         if (LZ_BLANK != 0) begin
            blank[k] = upper_zero;
         end else begin
            blank[k] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered value and guard blanking.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 2,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 2,
   parameter int LZ_BLANK    = 1,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load_valid,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic                    load_ready,
   output logic [3:0]              bcd_out,
   input  logic [6:0]              seg_in,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int CW = cnt_width(REFRESH_DIV, GUARD);
   localparam int DW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] G_LAST = CW'(GUARD - 1);
   localparam logic [CW-1:0] R_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);
   localparam logic          POL    = (ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{POL}};

   state_t                  state_r, state_s;
   logic [DW-1:0]           digit_r, digit_s;
   logic [CW-1:0]           cnt_r, cnt_s;
   logic                    frame_end_s;
   logic                    commit_s;
   logic                    accept_s;
   logic                    drive_last_s;
   logic [4*NUM_DIGITS-1:0] active_r, active_s, pending_r;
   logic                    pending_full_r;
   logic                    load_ready_r;
   logic [NUM_DIGITS-1:0]   blank_s;
   logic [NUM_DIGITS-1:0]   an_hot_s;
   logic [6:0]              seg_mask_s;
   logic [3:0]              bcd_r;
   logic [6:0]              seg_r;
   logic [NUM_DIGITS-1:0]   an_r;
   logic                    frame_done_r;

   seg7_lz_mask #(
      .NUM_DIGITS (NUM_DIGITS),
      .LZ_BLANK   (LZ_BLANK)
   ) u_lz_mask (
      .active (active_r),
      .blank  (blank_s)
   );

   // Scan sequencing: BLANK(k) for GUARD cycles, then DRIVE(k) for REFRESH_DIV cycles.
   always_comb begin
      state_s     = state_r;
      digit_s     = digit_r;
      cnt_s       = cnt_r;
      frame_end_s = 1'b0;
      if (!en) begin
         state_s = ST_BLANK;
         digit_s = '0;
         cnt_s   = '0;
      end else begin
         case (state_r)
            ST_BLANK: begin
               if (cnt_r == G_LAST) begin
                  state_s = ST_DRIVE;
                  cnt_s   = '0;
               end else begin
                  cnt_s = cnt_r + CW'(1);
               end
            end
            ST_DRIVE: begin
               if (cnt_r == R_LAST) begin
                  state_s = ST_BLANK;
                  cnt_s   = '0;
                  if (digit_r == D_LAST) begin
                     digit_s     = '0;
                     frame_end_s = 1'b1;
                  end else begin
                     digit_s = digit_r + DW'(1);
                  end
               end else begin
                  cnt_s = cnt_r + CW'(1);
               end
            end
            default: begin
               state_s = ST_BLANK;
               digit_s = '0;
               cnt_s   = '0;
            end
         endcase
      end
   end

   // Outputs are registered from the next scan position so they line up with the state.
   always_comb begin
      an_hot_s = '0;
      if (state_s == ST_DRIVE) begin
         an_hot_s[digit_s] = 1'b1;
      end else begin
         an_hot_s = '0;
      end
      drive_last_s = (state_s == ST_DRIVE) && (digit_s == D_LAST) && (cnt_s == R_LAST);
      if (blank_s[digit_r]) begin
         seg_mask_s = SEG_OFF;
      end else begin
         seg_mask_s = seg_in;
      end
      accept_s = load_valid & load_ready_r;
      commit_s = frame_end_s & pending_full_r;
      if (commit_s) begin
         active_s = pending_r;
      end else begin
         active_s = active_r;
      end
   end

   // Scan state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_BLANK;
         digit_r <= '0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         digit_r <= digit_s;
         cnt_r   <= cnt_s;
      end
   end

   // Double buffer: a load and a commit can never coincide since ready is low while pending is full.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_r       <= '0;
         pending_r      <= '0;
         pending_full_r <= 1'b0;
         load_ready_r   <= 1'b1;
      end else begin
         active_r <= active_s;
         if (accept_s) begin
            pending_r      <= load_value;
            pending_full_r <= 1'b1;
            load_ready_r   <= 1'b0;
         end else if (commit_s) begin
            pending_full_r <= 1'b0;
            load_ready_r   <= 1'b1;
         end else begin
            pending_full_r <= pending_full_r;
            load_ready_r   <= load_ready_r;
         end
      end
   end

   // Pin-facing registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_r        <= 4'd0;
         seg_r        <= seg_pol(SEG_OFF, POL);
         an_r         <= AN_OFF;
         frame_done_r <= 1'b0;
      end else begin
         bcd_r        <= active_s[{digit_s, 2'b00} +: 4];
         an_r         <= an_hot_s ^ AN_OFF;
         frame_done_r <= drive_last_s;
         if (en) begin
            seg_r <= seg_pol(seg_mask_s, POL);
         end else begin
            seg_r <= seg_pol(SEG_OFF, POL);
         end
      end
   end

   assign load_ready = load_ready_r;
   assign bcd_out    = bcd_r;
   assign seg_out    = seg_r;
   assign an         = an_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench: a frame-position model predicts every cycle's pin state; a monitor compares.
module tb_seg7_scan_ctrl;

   localparam int N     = 2;
   localparam int RD    = 4;
   localparam int G     = 2;
   localparam int SLOT  = G + RD;
   localparam int FRAME = N * SLOT;

   logic       clk = 1'b0;
   logic       rst, en, load_valid, load_ready, frame_done;
   logic [7:0] load_value;
   logic [3:0] bcd_out;
   logic [6:0] seg_in, seg_out;
   logic [1:0] an;

   always #5 clk = ~clk;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
         4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
         4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
         4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign seg_in = decode(bcd_out);

   seg7_scan_ctrl #(
      .NUM_DIGITS (N), .REFRESH_DIV (RD), .GUARD (G), .LZ_BLANK (1), .ACTIVE_LOW (1)
   ) dut (
      .clk (clk), .rst (rst), .en (en), .load_valid (load_valid), .load_value (load_value),
      .load_ready (load_ready), .bcd_out (bcd_out), .seg_in (seg_in), .seg_out (seg_out),
      .an (an), .frame_done (frame_done)
   );

   typedef struct packed {
      logic [1:0] an;
      logic [6:0] seg;
      logic       fd;
      logic       rdy;
      logic [3:0] bcd;
   } exp_t;

   exp_t exp_q[$];
   exp_t got, want;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference: display position is a tick within the frame; buffers are plain values.
   int         tick = 0;
   logic [7:0] m_active = 8'h00;
   logic [7:0] m_pending = 8'h00;
   bit         m_full = 1'b0;
   bit         m_accept = 1'b0;

   task automatic model_edge(output exp_t e);
      int         slot;
      int         off;
      logic [6:0] seg_e;
      bit         commit;
      m_accept = 1'b0;
      if (rst) begin
         tick = 0; m_active = 8'h00; m_pending = 8'h00; m_full = 1'b0;
         seg_e = 7'h7F;
      end else begin
         slot = tick / SLOT;
         if (!en) seg_e = 7'h7F;
         else if (slot > 0 && (m_active >> (4 * slot)) == 8'h00) seg_e = 7'h7F;
         else seg_e = ~decode(m_active[4*slot +: 4]);
         m_accept = load_valid && !m_full;
         commit   = en && (tick == FRAME - 1) && m_full;
         if (commit) begin
            m_active = m_pending;
            m_full   = 1'b0;
         end
         if (m_accept) begin
            m_pending = load_value;
            m_full    = 1'b1;
         end
         if (!en || tick == FRAME - 1) tick = 0;
         else tick = tick + 1;
      end
      slot  = tick / SLOT;
      off   = tick % SLOT;
      e.an  = (off >= G) ? ~(2'b01 << slot) : 2'b11;
      e.seg = seg_e;
      e.fd  = (tick == FRAME - 1);
      e.rdy = !m_full;
      e.bcd = m_active[4*slot +: 4];
   endtask

   task automatic cycle();
      exp_t e;
      model_edge(e);
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic send_load(input logic [7:0] v);
      bit done;
      done       = 1'b0;
      load_valid = 1'b1;
      load_value = v;
      for (int i = 0; i < 100 && !done; i++) begin
         cycle();
         done = m_accept;
      end
      load_valid = 1'b0;
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL load_accept value=%h accepted=%0b required=1", v, done);
      end
   endtask

   // Monitor: every pushed expectation is compared half a cycle after its edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = {an, seg_out, frame_done, load_ready, bcd_out};
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            if (n_bad <= 30)
               $display("FAIL pins t=%0t an=%b/%b seg=%h/%h fd=%b/%b rdy=%b/%b bcd=%h/%h (got/required)",
                        $time, got.an, want.an, got.seg, want.seg, got.fd, want.fd,
                        got.rdy, want.rdy, got.bcd, want.bcd);
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b1; load_valid = 1'b0; load_value = 8'h00;
      run(3);
      rst = 1'b0;
      run(12);
      run(3);
      send_load(8'h37);
      run(2 * FRAME);
      send_load(8'h12);
      send_load(8'h45);
      run(3 * FRAME);
      send_load(8'h05);
      run(2 * FRAME);
      send_load(8'h00);
      run(2 * FRAME);
      for (int i = 0; i < 2 * FRAME && tick != SLOT + G + 1; i++) cycle();
      en = 1'b0;
      run(3);
      en = 1'b1;
      run(FRAME + 2);
      send_load(8'h99);
      run(2);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      run(2 * FRAME);
      for (int i = 0; i < 1200; i++) begin
         rst        = ($urandom_range(0, 299) == 0);
         en         = ($urandom_range(0, 24) != 0);
         load_valid = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) == 0) load_value = 8'($urandom_range(0, 15));
         else load_value = 8'($urandom);
         cycle();
      end
      rst = 1'b0; en = 1'b1; load_valid = 1'b0;
      run(2);
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
